aqua_btb: RTL and testbench



---
 rtl/aqua_pkg.sv | 45 ++++
 rtl/aqua_btb_entry_upd.sv | 34 +++
 rtl/aqua_btb.sv | 106 ++++++++++
 tb/tb_aqua_btb.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/aqua_pkg.sv
// Shared types for the aqua fetch front end: branch records, 2-bit predictor
// states and the BTB entry layout.
package aqua_pkg;

  typedef enum logic [1:0] {
    NN = 2'b00,
    NT = 2'b01,
    TN = 2'b10,
    TT = 2'b11
  } predictor_t;

  typedef struct packed {
    logic [31:0] pc_lookup;
    logic [31:0] target;
    logic        taken;
    logic        update_en;
    logic        valid;
  } branch_t;

  // Sized for the smallest legal table (4 entries); narrower tags are zero-extended.
  localparam int TAG_W = 28;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    predictor_t       counter;
  } btb_entry_t;

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
    logic [31:0] shifted;
    shifted = pc >> (idx_w + 2);
    return shifted[TAG_W-1:0];
  endfunction

  function automatic predictor_t ctr_step(input predictor_t c, input logic taken);
    logic [1:0] raw;
    raw = c;
    if (taken)
      return (c == TT) ? TT : predictor_t'(raw + 2'd1);
    else
      return (c == NN) ? NN : predictor_t'(raw - 2'd1);
  endfunction

endpackage

// File: rtl/aqua_btb_entry_upd.sv
// Next-state of one BTB entry given a resolved branch that maps to its index.
// Chained twice by the top so a younger update sees the older one's result.
module aqua_btb_entry_upd
  import aqua_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  btb_entry_t i_entry,
  input  branch_t    i_upd,
  output btb_entry_t o_entry
);

  logic active;
  logic hit;

  always_comb begin
    o_entry = i_entry;
    active  = i_upd.valid & i_upd.update_en;
    hit     = i_entry.valid && (i_entry.tag == pc_tag(i_upd.pc_lookup, IDX_W));
    if (active) begin
      if (hit) begin
        o_entry.counter = ctr_step(i_entry.counter, i_upd.taken);
        if (i_upd.taken)
          o_entry.target = i_upd.target;
      end else if (i_upd.taken) begin
        o_entry.valid   = 1'b1;
        o_entry.tag     = pc_tag(i_upd.pc_lookup, IDX_W);
        o_entry.target  = i_upd.target;
        o_entry.counter = TN;
      end
    end
  end

endmodule

// File: rtl/aqua_btb.sv
// Direct-mapped BTB with 2-bit counters: two combinational lookup ports
// (PC, PC+4) and two resolved-branch update ports per cycle.
module aqua_btb
  import aqua_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  input  logic        i_fetch_valid,
  input  branch_t     i_update_instr1,
  input  branch_t     i_update_instr2,
  output logic        o_pred_taken,
  output logic        o_pred_slot,
  output logic [31:0] o_pred_target,
  output logic [31:0] o_next_pc,
  output logic [1:0]  o_hit
);

  btb_entry_t btb_reg [ENTRIES];

  logic [31:0]      slot_pc  [2];
  logic [IDX_W-1:0] rd_idx   [2];
  btb_entry_t       rd_entry [2];
  logic [1:0]       hit;
  logic [1:0]       pred;

  assign slot_pc[0] = i_pc;
  assign slot_pc[1] = i_pc + 32'd4;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign rd_idx[gi]   = slot_pc[gi][IDX_W+1:2];
      assign rd_entry[gi] = btb_reg[rd_idx[gi]];
      assign hit[gi]      = rd_entry[gi].valid &&
                            (rd_entry[gi].tag == pc_tag(slot_pc[gi], IDX_W));
      assign pred[gi]     = hit[gi] & rd_entry[gi].counter[1];
    end
  endgenerate

  // Slot 0 wins when both slots predict taken.
  always_comb begin
    o_pred_taken  = 1'b0;
    o_pred_slot   = 1'b0;
    o_pred_target = 32'd0;
    if (i_fetch_valid) begin
      if (pred[0]) begin
        o_pred_taken  = 1'b1;
        o_pred_target = rd_entry[0].target;
      end else if (pred[1]) begin
        o_pred_taken  = 1'b1;
        o_pred_slot   = 1'b1;
        o_pred_target = rd_entry[1].target;
      end
    end
    o_next_pc = o_pred_taken ? o_pred_target : i_pc + 32'd8;
  end

  assign o_hit = hit;

  logic [IDX_W-1:0] upd_idx1;
  logic [IDX_W-1:0] upd_idx2;
  logic             upd_act1;
  logic             upd_act2;
  btb_entry_t       upd_base2;
  btb_entry_t       upd_new1;
  btb_entry_t       upd_new2;
  logic             unused_pc_bits;

  assign upd_idx1       = i_update_instr1.pc_lookup[IDX_W+1:2];
  assign upd_idx2       = i_update_instr2.pc_lookup[IDX_W+1:2];
  assign upd_act1       = i_update_instr1.valid & i_update_instr1.update_en;
  assign upd_act2       = i_update_instr2.valid & i_update_instr2.update_en;
  assign unused_pc_bits = ^{i_update_instr1.pc_lookup[1:0], i_update_instr2.pc_lookup[1:0]};

  // instr2 builds on instr1's result when they target the same entry.
  assign upd_base2 = (upd_act1 && (upd_idx1 == upd_idx2)) ? upd_new1 : btb_reg[upd_idx2];

  aqua_btb_entry_upd #(.IDX_W(IDX_W)) u_upd1 (
    .i_entry (btb_reg[upd_idx1]),
    .i_upd   (i_update_instr1),
    .o_entry (upd_new1)
  );

  aqua_btb_entry_upd #(.IDX_W(IDX_W)) u_upd2 (
    .i_entry (upd_base2),
    .i_upd   (i_update_instr2),
    .o_entry (upd_new2)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        btb_reg[i] <= '0;
    end else begin
      if (upd_act1)
        btb_reg[upd_idx1] <= upd_new1;
      if (upd_act2)
        btb_reg[upd_idx2] <= upd_new2;
    end
  end

endmodule

// File: tb/tb_aqua_btb.sv
// Directed self-checking bench for aqua_btb (default 64 entries).
module tb_aqua_btb;
  import aqua_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        fetch_valid;
  branch_t     upd1;
  branch_t     upd2;
  logic        pred_taken;
  logic        pred_slot;
  logic [31:0] pred_target;
  logic [31:0] next_pc;
  logic [1:0]  hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aqua_btb #(.ENTRIES(64)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pc            (pc),
    .i_fetch_valid   (fetch_valid),
    .i_update_instr1 (upd1),
    .i_update_instr2 (upd2),
    .o_pred_taken    (pred_taken),
    .o_pred_slot     (pred_slot),
    .o_pred_target   (pred_target),
    .o_next_pc       (next_pc),
    .o_hit           (hit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic branch_t mk(input logic [31:0] bpc, input logic [31:0] tgt, input logic tk);
    branch_t b;
    b           = '0;
    b.pc_lookup = bpc;
    b.target    = tgt;
    b.taken     = tk;
    b.update_en = 1'b1;
    b.valid     = 1'b1;
    return b;
  endfunction

  task automatic upd(input branch_t b1, input branch_t b2);
    @(negedge clk);
    upd1 = b1;
    upd2 = b2;
    @(posedge clk);
    #1;
    upd1 = '0;
    upd2 = '0;
    $display("update: i1 v=%0b pc=%08h tk=%0b tgt=%08h | i2 v=%0b pc=%08h tk=%0b tgt=%08h",
             b1.valid, b1.pc_lookup, b1.taken, b1.target,
             b2.valid, b2.pc_lookup, b2.taken, b2.target);
  endtask

  task automatic lookup(input logic [31:0] lpc, input logic fv, input logic [1:0] e_hit,
                        input logic e_taken, input logic e_slot, input logic [31:0] e_tgt);
    logic [31:0] e_next;
    @(negedge clk);
    pc          = lpc;
    fetch_valid = fv;
    #1;
    e_next = e_taken ? e_tgt : lpc + 32'd8;
    $display("lookup: pc=%08h fv=%0b hit=%02b taken=%0b slot=%0b tgt=%08h next=%08h",
             lpc, fv, hit, pred_taken, pred_slot, pred_target, next_pc);
    if (fv)
      check($sformatf("hit@%08h", lpc), {30'd0, hit}, {30'd0, e_hit});
    check($sformatf("taken@%08h", lpc), {31'd0, pred_taken}, {31'd0, e_taken});
    check($sformatf("target@%08h", lpc), pred_target, e_taken ? e_tgt : 32'd0);
    check($sformatf("next@%08h", lpc), next_pc, e_next);
    if (e_taken)
      check($sformatf("slot@%08h", lpc), {31'd0, pred_slot}, {31'd0, e_slot});
  endtask

  localparam branch_t NONE = '0;

  initial begin
    rst_n       = 1'b0;
    pc          = 32'd0;
    fetch_valid = 1'b1;
    upd1        = '0;
    upd2        = '0;

    // Outputs while held in reset
    lookup(32'h100, 1, 2'b00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lookup(32'h100, 1, 2'b00, 0, 0, 0);

    // Slot 1 taken
    upd(mk(32'h104, 32'h200, 1), NONE);
    lookup(32'h100, 1, 2'b10, 1, 1, 32'h200);

    // Counter walk on 0x400 (index 0): TN,TT,TT,TT, then down
    upd(mk(32'h400, 32'h300, 1), NONE);
    lookup(32'h400, 1, 2'b01, 1, 0, 32'h300);
    for (int i = 0; i < 3; i++) upd(mk(32'h400, 32'h300, 1), NONE);
    upd(mk(32'h400, 32'h300, 0), NONE);   // TN
    lookup(32'h400, 1, 2'b01, 1, 0, 32'h300);
    upd(mk(32'h400, 32'h300, 0), NONE);   // NT
    lookup(32'h400, 1, 2'b01, 0, 0, 0);
    upd(mk(32'h400, 32'h300, 0), NONE);   // NN
    upd(mk(32'h400, 32'h300, 0), NONE);   // stays NN
    upd(mk(32'h400, 32'h300, 1), NONE);   // NT
    lookup(32'h400, 1, 2'b01, 0, 0, 0);
    upd(mk(32'h400, 32'h300, 1), NONE);   // TN
    lookup(32'h400, 1, 2'b01, 1, 0, 32'h300);

    // Same-index pair from a miss: allocate TN then step to TT
    upd(mk(32'h100, 32'h500, 1), mk(32'h100, 32'h500, 1));
    lookup(32'h100, 1, 2'b11, 1, 0, 32'h500);
    lookup(32'h100, 0, 2'b11, 0, 0, 0);
    upd(mk(32'h100, 32'h500, 0), NONE);   // TN
    lookup(32'h100, 1, 2'b11, 1, 0, 32'h500);
    upd(mk(32'h100, 32'h500, 0), NONE);   // NT, slot 1 takes over
    lookup(32'h100, 1, 2'b11, 1, 1, 32'h200);

    // Aliasing PC evicts 0x100
    upd(mk(32'h200, 32'h600, 1), NONE);
    lookup(32'h100, 1, 2'b10, 1, 1, 32'h200);
    lookup(32'h200, 1, 2'b01, 1, 0, 32'h600);

    // Two different indices in one cycle
    upd(mk(32'h108, 32'h700, 1), mk(32'h10C, 32'h800, 1));
    lookup(32'h108, 1, 2'b11, 1, 0, 32'h700);
    lookup(32'h10C, 1, 2'b01, 1, 0, 32'h800);

    // Not-taken hit keeps the stored target
    upd(mk(32'h108, 32'h700, 1), NONE);   // TT
    upd(mk(32'h108, 32'h999, 0), NONE);   // TN
    lookup(32'h108, 1, 2'b11, 1, 0, 32'h700);

    // Read during write returns pre-update contents
    @(negedge clk);
    pc   = 32'h110;
    upd1 = mk(32'h110, 32'hA00, 1);
    #1;
    $display("lookup (during write): pc=%08h hit=%02b taken=%0b next=%08h", pc, hit, pred_taken, next_pc);
    check("rdw_hit", {30'd0, hit}, 32'd0);
    check("rdw_next", next_pc, 32'h118);
    @(posedge clk);
    #1;
    upd1 = '0;
    lookup(32'h110, 1, 2'b01, 1, 0, 32'hA00);

    // Slot 1 wraps past 2^32
    upd(mk(32'h0, 32'h900, 1), NONE);
    lookup(32'hFFFF_FFFC, 1, 2'b10, 1, 1, 32'h900);
    lookup(32'hFFFF_FFF8, 1, 2'b00, 0, 0, 0);

    // Mid-run reset clears trained entries and drops updates made during it
    @(negedge clk);
    rst_n = 1'b0;
    lookup(32'h108, 1, 2'b00, 0, 0, 0);
    upd(mk(32'h120, 32'hB00, 1), NONE);
    @(negedge clk);
    rst_n = 1'b1;
    lookup(32'h108, 1, 2'b00, 0, 0, 0);
    lookup(32'h10C, 1, 2'b00, 0, 0, 0);
    lookup(32'h120, 1, 2'b00, 0, 0, 0);

    // Not-taken update to an empty entry allocates nothing
    upd(mk(32'h130, 32'hC00, 0), NONE);
    lookup(32'h130, 1, 2'b00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
